// File: rtl/cv32e40p_instr_obi_arbiter_if.sv
// ============================================================================
// Module      : cv32e40p_instr_obi_arbiter_if
// Description : Bus bundle for the two-master instruction OBI arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cv32e40p_instr_obi_arbiter_if;
  logic        m0_req_i;
  logic [31:0] m0_addr_i;
  logic        m0_gnt_o;
  logic        m0_rvalid_o;
  logic [31:0] m0_rdata_o;
  logic        m0_err_o;

  logic        m1_req_i;
  logic [31:0] m1_addr_i;
  logic        m1_gnt_o;
  logic        m1_rvalid_o;
  logic [31:0] m1_rdata_o;
  logic        m1_err_o;

  logic        obi_req_o;
  logic [31:0] obi_addr_o;
  logic        obi_gnt_i;
  logic        obi_rvalid_i;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;

  logic        busy_o;
  logic        protocol_err_o;

  // Arbiter side
  modport slave (
    input  m0_req_i, m0_addr_i, m1_req_i, m1_addr_i,
    input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    output obi_req_o, obi_addr_o, busy_o, protocol_err_o
  );

  // Environment side: masters plus downstream memory
  modport master (
    output m0_req_i, m0_addr_i, m1_req_i, m1_addr_i,
    output obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    input  obi_req_o, obi_addr_o, busy_o, protocol_err_o
  );
endinterface

`default_nettype wire

// File: rtl/cv32e40p_instr_obi_arbiter.sv
// ============================================================================
// Module      : cv32e40p_instr_obi_arbiter
// Description : Round-robin two-master arbiter onto one instruction OBI port
//               with an in-order owner FIFO for response routing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_instr_obi_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  wire                              clk,
  input  wire                              rst,
  cv32e40p_instr_obi_arbiter_if.slave      bus
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] c_max      = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(MAX_OUTSTANDING - 1);

  logic [CNT_W-1:0]           r_cnt;
  logic [MAX_OUTSTANDING-1:0] r_owner;
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic                       r_rr_last;
  logic                       r_locked;
  logic                       r_lock_id;
  logic                       r_protocol_err;

  logic        w_sel;
  logic        w_obi_req;
  logic        w_push;
  logic        w_pop;
  logic        w_head;
  logic [31:0] w_addr_sel;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  // A held lock overrides arbitration so req/addr stay stable until grant.
  always_comb begin
    w_sel = 1'b0;
    if (r_locked) begin
      w_sel = r_lock_id;
    end else if (bus.m0_req_i && bus.m1_req_i) begin
      w_sel = ~r_rr_last;
    end else begin
      w_sel = bus.m1_req_i;
    end
  end

  assign w_addr_sel = w_sel ? bus.m1_addr_i : bus.m0_addr_i;
  assign w_obi_req  = (r_locked | bus.m0_req_i | bus.m1_req_i) &
                      ((r_cnt < c_max) | r_locked);
  assign w_push     = w_obi_req & bus.obi_gnt_i;
  assign w_pop      = bus.obi_rvalid_i & (r_cnt != '0);
  assign w_head     = r_owner[r_rd_ptr];

  assign bus.obi_req_o  = w_obi_req;
  assign bus.obi_addr_o = {w_addr_sel[31:2], 2'b00};

  assign bus.m0_gnt_o    = w_push & ~w_sel;
  assign bus.m1_gnt_o    = w_push &  w_sel;
  assign bus.m0_rvalid_o = w_pop  & ~w_head;
  assign bus.m1_rvalid_o = w_pop  &  w_head;
  assign bus.m0_rdata_o  = bus.obi_rdata_i;
  assign bus.m1_rdata_o  = bus.obi_rdata_i;
  assign bus.m0_err_o    = bus.obi_err_i;
  assign bus.m1_err_o    = bus.obi_err_i;

  assign bus.busy_o         = (r_cnt != '0);
  assign bus.protocol_err_o = r_protocol_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_owner        <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_rr_last      <= 1'b1;
      r_locked       <= 1'b0;
      r_lock_id      <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_owner[r_wr_ptr] <= w_sel;
        r_wr_ptr          <= ptr_inc(r_wr_ptr);
        r_rr_last         <= w_sel;
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase

      if (w_obi_req && !bus.obi_gnt_i) begin
        r_locked  <= 1'b1;
        r_lock_id <= w_sel;
      end else if (w_push) begin
        r_locked  <= 1'b0;
      end

      if (bus.obi_rvalid_i && (r_cnt == '0)) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_instr_obi_arbiter.sv
// ============================================================================
// Module      : tb_cv32e40p_instr_obi_arbiter
// Description : Self-checking bench: vector table, directed sequences and
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40p_instr_obi_arbiter;
  localparam int MAX = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  cv32e40p_instr_obi_arbiter_if bus ();

  cv32e40p_instr_obi_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  in_f;   // m0_req m1_req gnt rvalid
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] rdata;
    logic [5:0]  out_f;  // obi_req g0 g1 rv0 rv1 busy_after
    logic [31:0] addr;
    logic        perr;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(input logic [3:0] in_f, input logic [31:0] rdata,
                              input logic [5:0] out_f, input logic [31:0] addr,
                              input logic perr);
    vec_t v;
    v.in_f  = in_f;
    v.a0    = 32'h0000_0104;
    v.a1    = 32'h0000_020B;
    v.rdata = rdata;
    v.out_f = out_f;
    v.addr  = addr;
    v.perr  = perr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic m0, input logic m1, input logic [31:0] a0,
                       input logic [31:0] a1, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic err);
    bus.m0_req_i     = m0;
    bus.m1_req_i     = m1;
    bus.m0_addr_i    = a0;
    bus.m1_addr_i    = a1;
    bus.obi_gnt_i    = gnt;
    bus.obi_rvalid_i = rv;
    bus.obi_rdata_i  = rdata;
    bus.obi_err_i    = err;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference model state
  int   q[$];
  logic m_rr_last, m_locked, m_lock_id, m_perr;

  initial begin
    logic m0, m1, gnt, rv, err, sel, e_req;
    logic [31:0] a0, a1, rdata, e_addr;

    tbl[0] = mk(4'b1110, 32'h0,          6'b110001, 32'h104, 1'b0);
    tbl[1] = mk(4'b1111, 32'h1000_0000,  6'b101101, 32'h208, 1'b0);
    tbl[2] = mk(4'b1111, 32'h1000_0001,  6'b110011, 32'h104, 1'b0);
    tbl[3] = mk(4'b1100, 32'h0,          6'b100001, 32'h208, 1'b0);
    tbl[4] = mk(4'b1010, 32'h0,          6'b101001, 32'h208, 1'b0);
    tbl[5] = mk(4'b1010, 32'h0,          6'b000001, 32'h104, 1'b0);
    tbl[6] = mk(4'b1011, 32'h1000_0002,  6'b000101, 32'h104, 1'b0);
    tbl[7] = mk(4'b1011, 32'h1000_0003,  6'b110011, 32'h104, 1'b0);
    tbl[8] = mk(4'b0001, 32'h1000_0004,  6'b000100, 32'h104, 1'b0);
    tbl[9] = mk(4'b0001, 32'h0000_0005,  6'b000000, 32'h104, 1'b1);

    // Reset with both requests high
    drive(1'b1, 1'b1, 32'h104, 32'h208, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    #3;
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_perr", 32'(bus.protocol_err_o), 32'd0);
    chk("rst_gnt", {30'd0, bus.m0_gnt_o, bus.m1_gnt_o}, 32'd0);
    chk("rst_rvalid", {30'd0, bus.m0_rvalid_o, bus.m1_rvalid_o}, 32'd0);
    drive(1'b0, 1'b0, 32'h104, 32'h208, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("rst_obi_req_idle", 32'(bus.obi_req_o), 32'd0);
    tick();
    rst = 1'b0;

    // Vector table, starting from reset state
    foreach (tbl[i]) begin
      drive(tbl[i].in_f[3], tbl[i].in_f[2], tbl[i].a0, tbl[i].a1, tbl[i].in_f[1],
            tbl[i].in_f[0], tbl[i].rdata, tbl[i].rdata[0]);
      #3;
      chk($sformatf("tbl%0d_req", i), 32'(bus.obi_req_o), 32'(tbl[i].out_f[5]));
      if (tbl[i].out_f[5]) chk($sformatf("tbl%0d_addr", i), bus.obi_addr_o, tbl[i].addr);
      chk($sformatf("tbl%0d_gnt", i), {30'd0, bus.m0_gnt_o, bus.m1_gnt_o},
          {30'd0, tbl[i].out_f[4:3]});
      chk($sformatf("tbl%0d_rvalid", i), {30'd0, bus.m0_rvalid_o, bus.m1_rvalid_o},
          {30'd0, tbl[i].out_f[2:1]});
      chk($sformatf("tbl%0d_rdata", i), bus.m1_rdata_o, tbl[i].rdata);
      chk($sformatf("tbl%0d_err", i), 32'(bus.m0_err_o), 32'(tbl[i].rdata[0]));
      tick();
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy_o), 32'(tbl[i].out_f[0]));
      chk($sformatf("tbl%0d_perr", i), 32'(bus.protocol_err_o), 32'(tbl[i].perr));
    end

    // Protocol error is sticky and cleared asynchronously by reset
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("perr_sticky", 32'(bus.protocol_err_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("perr_async_clear", 32'(bus.protocol_err_o), 32'd0);
    tick();
    rst = 1'b0;

    // Contention: alternating grants, responses one cycle later
    do_reset();
    for (int n = 0; n < 8; n++) begin
      drive(1'b1, 1'b1, 32'h400 + 32'(n) * 4, 32'h800 + 32'(n) * 4, 1'b1, n > 0,
            32'h1000_0000 + 32'(n) - 1, 1'b0);
      #3;
      chk("cont_gnt", {30'd0, bus.m0_gnt_o, bus.m1_gnt_o},
          (n % 2 == 0) ? 32'd2 : 32'd1);
      if (n > 0) begin
        chk("cont_rvalid", {30'd0, bus.m0_rvalid_o, bus.m1_rvalid_o},
            ((n - 1) % 2 == 0) ? 32'd2 : 32'd1);
        chk("cont_rdata", ((n - 1) % 2 == 0) ? bus.m0_rdata_o : bus.m1_rdata_o,
            32'h1000_0000 + 32'(n) - 1);
      end
      tick();
    end

    // Stall stability: lock holds m0 and its address until granted
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(c < 4, c >= 1, 32'h80, 32'h200, c >= 3, 1'b0, 32'h0, 1'b0);
      #3;
      chk("stall_req", 32'(bus.obi_req_o), 32'd1);
      chk("stall_addr", bus.obi_addr_o, (c < 4) ? 32'h80 : 32'h200);
      chk("stall_gnt", {30'd0, bus.m0_gnt_o, bus.m1_gnt_o},
          (c == 3) ? 32'd2 : (c == 4) ? 32'd1 : 32'd0);
      tick();
    end

    // Randomized traffic against the queue model
    do_reset();
    q.delete();
    m_rr_last = 1'b1;
    m_locked  = 1'b0;
    m_lock_id = 1'b0;
    m_perr    = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      m0    = ($urandom_range(0, 3) != 0);
      m1    = ($urandom_range(0, 2) != 0);
      a0    = $urandom;
      a1    = $urandom;
      gnt   = ($urandom_range(0, 2) != 0);
      rv    = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 99) == 0);
      rdata = $urandom;
      err   = $urandom_range(0, 1) == 1;
      drive(m0, m1, a0, a1, gnt, rv, rdata, err);

      if (m_locked) sel = m_lock_id;
      else if (m0 && m1) sel = ~m_rr_last;
      else sel = m1;
      e_req  = (m_locked || m0 || m1) && (q.size() < MAX || m_locked);
      e_addr = sel ? {a1[31:2], 2'b00} : {a0[31:2], 2'b00};

      #3;
      chk("rnd_req", 32'(bus.obi_req_o), 32'(e_req));
      if (e_req) chk("rnd_addr", bus.obi_addr_o, e_addr);
      chk("rnd_gnt", {30'd0, bus.m0_gnt_o, bus.m1_gnt_o},
          {30'd0, e_req && gnt && !sel, e_req && gnt && sel});
      chk("rnd_rvalid", {30'd0, bus.m0_rvalid_o, bus.m1_rvalid_o},
          {30'd0, rv && q.size() > 0 && q[0] == 0, rv && q.size() > 0 && q[0] == 1});
      chk("rnd_rsp", {bus.m0_rdata_o[30:0], bus.m1_err_o}, {rdata[30:0], err});

      if (rv && q.size() > 0) void'(q.pop_front());
      else if (rv) m_perr = 1'b1;
      if (e_req && gnt) begin
        q.push_back(int'(sel));
        m_rr_last = sel;
        m_locked  = 1'b0;
      end else if (e_req) begin
        m_locked  = 1'b1;
        m_lock_id = sel;
      end

      tick();
      chk("rnd_busy", 32'(bus.busy_o), 32'(q.size() != 0));
      chk("rnd_perr", 32'(bus.protocol_err_o), 32'(m_perr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cv32e40p_instr_obi_arbiter.md
# cv32e40p_instr_obi_arbiter

Two-master arbiter for the core's single instruction-side OBI port. Master 0 is the prefetch buffer's OBI interface. Master 1 is the self-test fetch engine. The block uses round-robin arbitration and holds the choice stable while a request is waiting for its grant. It records the owner of every granted transaction in an in-order owner FIFO, and routes each in-order `rvalid`/`rdata`/`err` response back to the master that issued it. It sits between the masters and the instruction memory or cache port.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum granted-but-unanswered transactions. Must be a power of 2 and ≥1.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `m0_req_i`  in  1  master 0 request.
- `m0_addr_i`  in  32  master 0 word address; bits [1:0] ignored, forwarded as 00.
- `m0_gnt_o`  out  1  master 0 grant.
- `m0_rvalid_o`  out  1  master 0 response valid.
- `m0_rdata_o`  out  32  master 0 response data.
- `m0_err_o`  out  1  master 0 response error.
- `m1_req_i`, `m1_addr_i`, `m1_gnt_o`, `m1_rvalid_o`, `m1_rdata_o`, `m1_err_o`: same widths and meanings for master 1.
- `obi_req_o`  out  1  downstream request.
- `obi_addr_o`  out  32  downstream address.
- `obi_gnt_i`  in  1  downstream grant.
- `obi_rvalid_i`  in  1  downstream response valid.
- `obi_rdata_i`  in  32  downstream response data.
- `obi_err_i`  in  1  downstream response error.
- `busy_o`  out  1  high while outstanding count ≠ 0.
- `protocol_err_o`  out  1  sticky: an `rvalid` arrived with no transaction outstanding.

## Operation
- State:
  - `cnt` (0..MAX_OUTSTANDING), number of outstanding transactions.
  - Owner FIFO, depth MAX_OUTSTANDING, 1 bit per entry.
  - `rr_last`, the master granted last.
  - `locked` and `lock_id`, which hold the arbitration choice.
  - `protocol_err` flag.
- Arbitration (`sel`):
  - If `locked`: `sel = lock_id`.
  - If exactly one master requests: `sel` = that master.
  - If both request: `sel = ~rr_last`.
- Issue:
  - `obi_req_o = (locked | m0_req_i | m1_req_i) & (cnt < MAX_OUTSTANDING | locked)`.
  - `obi_addr_o = {addr_sel[31:2], 2'b00}`.
- Lock:
  - Set to `sel` when `obi_req_o & ~obi_gnt_i`.
  - Cleared on a cycle with `obi_req_o & obi_gnt_i`.
  - Together these keep `req`/`addr` stable until grant, as OBI requires.
- Grant: `mX_gnt_o = obi_req_o & obi_gnt_i & (sel == X)`.
  - On a grant handshake: push `sel` into the owner FIFO, increment `cnt`, set `rr_last = sel`.
- Response:
  - `mX_rvalid_o = obi_rvalid_i & (cnt ≠ 0) & (fifo_head == X)`.
  - `rdata`/`err` are routed to both masters unqualified.
  - On `obi_rvalid_i & cnt ≠ 0`: pop the FIFO and decrement `cnt`.
- Simultaneous grant and rvalid: push and pop in the same cycle; `cnt` is unchanged. At `cnt == MAX_OUTSTANDING`, the pop frees the slot only from the next cycle.
- Full: with `cnt == MAX_OUTSTANDING` and `~locked`, `obi_req_o` stays 0. A locked request is never withdrawn. Lock is only taken when `cnt < MAX`, so overflow cannot occur.
- Empty: `obi_rvalid_i` with `cnt == 0` sets `protocol_err_o`, with no pop, no count change and no `mX_rvalid_o`.
- Wrap-around: FIFO pointers are `$clog2(MAX_OUTSTANDING)` bits wide and wrap naturally. `cnt` is `$clog2(MAX_OUTSTANDING)+1` bits wide.
- Reset asserted mid-operation:
  - All state clears immediately, including any held lock.
  - Responses from pre-reset transactions that arrive after reset raise `protocol_err_o`. The integration must avoid this.

## Timing
- `req`→`obi_req_o`, `gnt`→`mX_gnt_o`, and `rvalid`→`mX_rvalid_o` are combinational (zero latency).
- FIFO, `cnt`, `rr_last`, `lock` and `protocol_err` are registered.
- Reset values:
  - `cnt = 0`, FIFO empty, `rr_last = 1` (so master 0 wins first contention), `locked = 0`, `protocol_err_o = 0`, `busy_o = 0`.
  - With request inputs low: `obi_req_o = 0`, `mX_gnt_o = 0`, `mX_rvalid_o = 0`.
- Grant throughput is one per cycle while `cnt < MAX`.
- Minimum response latency is the cycle after grant. The FIFO is not fall-through for the same-cycle grant.

## Test plan
- Reset: drive `rst` with requests high → all outputs at reset values listed above. After release, the first contended grant goes to master 0.
- Contention:
  - Setup: both masters hold req; downstream grants every cycle and rvalid one cycle later.
  - Required response: grants alternate m0, m1, m0, m1.
  - Required response: each `mX_rvalid_o` matches the issue order, with `rdata` 0x1000_0000+n delivered to the correct master.
- Stall stability:
  - Setup: m0 requests addr 0x80 and `obi_gnt_i` is held low 3 cycles; m1 raises req in cycle 1 with addr 0x200.
  - Required response: `obi_addr_o` stays 0x80 and sel stays m0 until grant; m1 is granted next.
- Full: with MAX_OUTSTANDING=2, grant 2 with no rvalid → `obi_req_o` = 0 and `busy_o` = 1. Then rvalid → `obi_req_o` returns the next cycle and `cnt` goes to 1.
- Simultaneous: grant and rvalid in the same cycle at `cnt` = 1 → `cnt` stays 1 and the FIFO head advances correctly.
- Protocol error: rvalid with `cnt` = 0 → `protocol_err_o` = 1 sticky and no `mX_rvalid_o`. Reset clears it to 0.
